// File: rtl/core_data_responder.sv
// rtl/core_data_responder.sv - Core data bus slave: byte-maskable data RAM plus MMIO console FIFO and machine timer.
module core_data_responder #(
    parameter int unsigned RAM_WORDS = 4096,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter int unsigned TXQ_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_ren,
    input  logic        bus_wen,
    input  logic [31:0] bus_raddr,
    input  logic [31:0] bus_waddr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_bytemask,
    output logic [31:0] bus_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq_timer
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          PW        = $clog2(TXQ_DEPTH);
    localparam int          CW        = $clog2(TXQ_DEPTH + 1);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    localparam logic [5:0] OFF_TXDATA = 6'd0;
    localparam logic [5:0] OFF_STATUS = 6'd1;
    localparam logic [5:0] OFF_MT_LO  = 6'd2;
    localparam logic [5:0] OFF_MT_HI  = 6'd3;
    localparam logic [5:0] OFF_CMP_LO = 6'd4;
    localparam logic [5:0] OFF_CMP_HI = 6'd5;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // Address decode; RAM takes priority should the two windows ever overlap.
    logic [31:0] r_off, w_off;
    logic        r_is_ram, r_is_mmio, w_is_ram, w_is_mmio;
    logic [5:0]  r_word, w_word;

    assign r_off     = bus_raddr - RAM_BASE;
    assign w_off     = bus_waddr - RAM_BASE;
    assign r_is_ram  = r_off < RAM_BYTES;
    assign w_is_ram  = w_off < RAM_BYTES;
    assign r_is_mmio = !r_is_ram && (bus_raddr[31:8] == MMIO_BASE[31:8]);
    assign w_is_mmio = !w_is_ram && (bus_waddr[31:8] == MMIO_BASE[31:8]);
    assign r_word    = bus_raddr[7:2];
    assign w_word    = bus_waddr[7:2];

    logic [31:0]   mem [RAM_WORDS];
    logic [AW-1:0] ridx, widx;

    assign ridx = r_off[AW+1:2];
    assign widx = w_off[AW+1:2];

    always_ff @(posedge clk) begin
        if (bus_wen && w_is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (bus_bytemask[i]) mem[widx][8*i +: 8] <= bus_wdata[8*i +: 8];
            end
        end
    end

    logic [7:0]    txq [TXQ_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          overflow, full;
    logic          push_req, push_ok, pop, ovf_clr;

    assign full     = (count == CW'(TXQ_DEPTH));
    assign tx_valid = (count != '0);
    assign tx_data  = txq[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    assign push_req = bus_wen && w_is_mmio && (w_word == OFF_TXDATA) && bus_bytemask[0];
    // A full queue still accepts when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_clr  = bus_wen && w_is_mmio && (w_word == OFF_STATUS) &&
                      bus_bytemask[0] && bus_wdata[1];

    always_ff @(posedge clk) begin
        if (push_ok) txq[wr_ptr] <= bus_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

    logic [63:0] mtime, mtimecmp;
    logic        mt_lo_wr, mt_hi_wr, cmp_lo_wr, cmp_hi_wr, any_lane;

    assign any_lane  = |bus_bytemask;
    assign mt_lo_wr  = bus_wen && w_is_mmio && any_lane && (w_word == OFF_MT_LO);
    assign mt_hi_wr  = bus_wen && w_is_mmio && any_lane && (w_word == OFF_MT_HI);
    assign cmp_lo_wr = bus_wen && w_is_mmio && (w_word == OFF_CMP_LO);
    assign cmp_hi_wr = bus_wen && w_is_mmio && (w_word == OFF_CMP_HI);

    // A software write to either mtime half freezes the whole counter for that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            irq_timer <= 1'b0;
        end else begin
            irq_timer <= (mtime >= mtimecmp);
            if (mt_lo_wr)
                mtime[31:0] <= merge_bytes(mtime[31:0], bus_wdata, bus_bytemask);
            else if (mt_hi_wr)
                mtime[63:32] <= merge_bytes(mtime[63:32], bus_wdata, bus_bytemask);
            else
                mtime <= mtime + 64'd1;
            if (cmp_lo_wr)
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], bus_wdata, bus_bytemask);
            if (cmp_hi_wr)
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus_wdata, bus_bytemask);
        end
    end

    logic [31:0] mmio_rd, rd_word;

    always_comb begin
        mmio_rd = '0;
        case (r_word)
            OFF_STATUS: mmio_rd = {16'b0, 8'(count), 6'b0, overflow, full};
            OFF_MT_LO:  mmio_rd = mtime[31:0];
            OFF_MT_HI:  mmio_rd = mtime[63:32];
            OFF_CMP_LO: mmio_rd = mtimecmp[31:0];
            OFF_CMP_HI: mmio_rd = mtimecmp[63:32];
            default:    mmio_rd = '0;
        endcase
        rd_word = '0;
        if (r_is_ram)       rd_word = mem[ridx];
        else if (r_is_mmio) rd_word = mmio_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       bus_rdata <= '0;
        else if (bus_ren) bus_rdata <= rd_word;
    end

endmodule

// File: tb/tb_core_data_responder.sv
// tb/tb_core_data_responder.sv - Randomized bench for core_data_responder against a transaction-level model.
module tb_core_data_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_ren = 1'b0, bus_wen = 1'b0;
    logic [31:0] bus_raddr = '0, bus_waddr = '0, bus_wdata = '0;
    logic [3:0]  bus_bytemask = '0;
    logic [31:0] bus_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        irq_timer;

    always #5 clk = ~clk;

    core_data_responder dut (
        .clk(clk), .rst_n(rst_n),
        .bus_ren(bus_ren), .bus_wen(bus_wen),
        .bus_raddr(bus_raddr), .bus_waddr(bus_waddr),
        .bus_wdata(bus_wdata), .bus_bytemask(bus_bytemask),
        .bus_rdata(bus_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .irq_timer(irq_timer)
    );

    localparam logic [31:0] MM = 32'h1000_0000;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: words, a byte queue, and a 64-bit timer value.
    logic [31:0] m_ram [int];
    bit   [7:0]  m_q [$];
    bit          m_ovf;
    logic [63:0] m_mtime, m_cmp;
    bit          m_irq;
    logic [31:0] m_rdata;

    function automatic bit is_ram(input logic [31:0] a);
        return a < 32'(4096 * 4);
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return !is_ram(a) && (a[31:8] == MM[31:8]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int sz;
        sz = m_q.size();
        if (is_ram(a)) return m_ram.exists(int'(a >> 2)) ? m_ram[int'(a >> 2)] : 32'h0;
        if (!is_mmio(a)) return 32'h0;
        case (a[7:2])
            6'd1: return {16'b0, 8'(sz), 6'b0, m_ovf, 1'(sz == 8)};
            6'd2: return m_mtime[31:0];
            6'd3: return m_mtime[63:32];
            6'd4: return m_cmp[31:0];
            6'd5: return m_cmp[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_mtime = 64'd0;
        m_cmp   = '1;
        m_irq   = 1'b0;
        m_rdata = 32'h0;
    endtask

    // One bus cycle: drive, check pre-edge FIFO head, advance the model, check post-edge outputs.
    task automatic step(input bit r, input logic [31:0] ra, input bit w, input logic [31:0] wa,
                        input logic [31:0] wd, input logic [3:0] m, input bit rdy);
        bit pop, push, full, tw;
        bus_ren = r; bus_raddr = ra; bus_wen = w; bus_waddr = wa;
        bus_wdata = wd; bus_bytemask = m; tx_ready = rdy;
        #1;
        check_eq("tx_valid", 64'(tx_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) check_eq("tx_data", 64'(tx_data), 64'(m_q[0]));
        if (r) m_rdata = m_read(ra);
        m_irq = (m_mtime >= m_cmp);
        pop  = (m_q.size() != 0) && rdy;
        full = (m_q.size() == 8);
        push = w && is_mmio(wa) && (wa[7:2] == 6'd0) && m[0];
        tw   = 1'b0;
        if (w && is_ram(wa)) m_ram[int'(wa >> 2)] = merge(m_ram[int'(wa >> 2)], wd, m);
        if (w && is_mmio(wa)) begin
            case (wa[7:2])
                6'd1: if (m[0] && wd[1]) m_ovf = 1'b0;
                6'd2: if (m != 0) begin m_mtime[31:0]  = merge(m_mtime[31:0], wd, m);  tw = 1'b1; end
                6'd3: if (m != 0) begin m_mtime[63:32] = merge(m_mtime[63:32], wd, m); tw = 1'b1; end
                6'd4: m_cmp[31:0]  = merge(m_cmp[31:0], wd, m);
                6'd5: m_cmp[63:32] = merge(m_cmp[63:32], wd, m);
                default: ;
            endcase
        end
        if (!tw) m_mtime = m_mtime + 64'd1;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (!full || pop) m_q.push_back(wd[7:0]);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("rdata", 64'(bus_rdata), 64'(m_rdata));
        check_eq("irq_timer", 64'(irq_timer), 64'(m_irq));
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, rdy);
    endtask

    initial begin
        int first;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rdata", 64'(bus_rdata), 64'h0);
        check_eq("rst_tx_valid", 64'(tx_valid), 64'h0);
        check_eq("rst_irq", 64'(irq_timer), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            step(1'b0, 0, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);

        // Full write then byte-lane update of the same word
        step(1'b0, 0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0);
        step(1'b1, 32'h40, 1'b0, 0, 0, 4'h0, 1'b0);
        check_eq("t1_read", 64'(bus_rdata), 64'hDEAD_BEEF);
        idle(1'b0); idle(1'b0);
        check_eq("t1_hold", 64'(bus_rdata), 64'hDEAD_BEEF);
        step(1'b0, 0, 1'b1, 32'h40, 32'h00AA_0000, 4'b0100, 1'b0);
        step(1'b1, 32'h40, 1'b0, 0, 0, 4'h0, 1'b0);
        check_eq("t2_lane", 64'(bus_rdata), 64'hDEAA_BEEF);
        step(1'b1, 32'h2000_0000, 1'b0, 0, 0, 4'h0, 1'b0);
        check_eq("t2_unmapped", 64'(bus_rdata), 64'h0);
        step(1'b1, 32'h40, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 1'b0);
        check_eq("rw_same_word", 64'(bus_rdata), 64'hDEAA_BEEF);
        step(1'b0, 0, 1'b1, 32'h40, 32'hDEAA_BEEF, 4'hF, 1'b0);

        // Overflow, drain, sticky clear
        for (int i = 1; i <= 9; i++) step(1'b0, 0, 1'b1, MM, 32'(i), 4'h1, 1'b0);
        step(1'b1, MM + 4, 1'b0, 0, 0, 4'h0, 1'b0);
        check_eq("t3_status_full", 64'(bus_rdata), 64'h0000_0803);
        for (int i = 0; i < 8; i++) idle(1'b1);
        check_eq("t3_drained", 64'(tx_valid), 64'h0);
        step(1'b0, 0, 1'b1, MM + 4, 32'h2, 4'h1, 1'b0);
        step(1'b1, MM + 4, 1'b0, 0, 0, 4'h0, 1'b0);
        check_eq("t3_ovf_clear", 64'(bus_rdata), 64'h0);

        // Push and pop together while full
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, MM, 32'(8'h11 + i), 4'h1, 1'b0);
        step(1'b0, 0, 1'b1, MM, 32'h99, 4'h1, 1'b1);
        step(1'b1, MM + 4, 1'b0, 0, 0, 4'h0, 1'b0);
        check_eq("t4_status", 64'(bus_rdata), 64'h0000_0801);
        for (int i = 0; i < 7; i++) idle(1'b1);
        check_eq("t4_last_byte", 64'(tx_data), 64'h99);
        idle(1'b1);
        check_eq("t4_empty", 64'(tx_valid), 64'h0);

        // mtime carry from lo into hi
        step(1'b0, 0, 1'b1, MM + 8, 32'hFFFF_FFFF, 4'hF, 1'b0);
        step(1'b0, 0, 1'b1, MM + 12, 32'h0, 4'hF, 1'b0);
        idle(1'b0);
        step(1'b1, MM + 12, 1'b0, 0, 0, 4'h0, 1'b0);
        check_eq("t5_carry", 64'(bus_rdata), 64'h1);

        // irq_timer rises the cycle after mtime reaches 20
        step(1'b0, 0, 1'b1, MM + 20, 32'h0, 4'hF, 1'b0);
        step(1'b0, 0, 1'b1, MM + 16, 32'd20, 4'hF, 1'b0);
        step(1'b0, 0, 1'b1, MM + 12, 32'h0, 4'hF, 1'b0);
        step(1'b0, 0, 1'b1, MM + 8, 32'h0, 4'hF, 1'b0);
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            idle(1'b0);
            if (irq_timer && first == 0) first = i;
        end
        check_eq("t6_irq_rise", 64'(first), 64'd21);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, MM, 32'(8'hA0 + i), 4'h1, 1'b0);
        step(1'b1, 32'h40, 1'b0, 0, 0, 4'h0, 1'b1);
        bus_ren = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_tx_valid", 64'(tx_valid), 64'h0);
        check_eq("t6_rst_rdata", 64'(bus_rdata), 64'h0);
        check_eq("t6_rst_irq", 64'(irq_timer), 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int n = 0; n < 1500; n++) begin
            int kind;
            bit r, w, rdy;
            logic [31:0] ra, wa, wd;
            logic [3:0] m;
            kind = $urandom_range(0, 9);
            r = $urandom_range(0, 1) == 1;
            rdy = $urandom_range(0, 2) == 0;
            wd = $urandom;
            m = 4'($urandom);
            w = 1'b1;
            case ($urandom_range(0, 2))
                0: ra = 32'($urandom_range(0, 16) * 4);
                1: ra = MM + 32'($urandom_range(0, 7) * 4);
                default: ra = 32'h2000_0000 | 32'($urandom_range(0, 65535));
            endcase
            case (kind)
                0, 1, 2, 3: wa = 32'($urandom_range(0, 16) * 4);
                4: wa = MM;
                5: wa = MM + 4;
                6: begin
                    wa = MM + 32'($urandom_range(2, 7) * 4);
                    w = ($urandom_range(0, 3) == 0);
                end
                7: wa = 32'h2000_0000 | 32'($urandom_range(0, 65535));
                default: begin wa = 0; w = 1'b0; end
            endcase
            step(r, ra, w, wa, wd, m, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
